parent_ret_rob: RTL and testbench

// - Parent-side consumer of the per-parent return FIFO produced by the return arbiter.
// - One instance per parent.
// - Records every call the parent issues (target child, in issue order) and allocates a reorder slot.
// - Drains returns {child_id, ret_val} as they arrive in any cross-child order.
// - Steers each return to the oldest outstanding slot of that child; a child returns strictly in call order.
// - Releases results to the parent core in original call order.

---
 rtl/func_arbiter_pkg.sv | 20 ++
 rtl/parent_ret_rob_if.sv | 31 +++
 rtl/parent_ret_rob_ret_tag_fifo.sv | 42 ++++
 rtl/parent_ret_rob.sv | 110 +++++++++++
 tb/tb_parent_ret_rob.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/func_arbiter_pkg.sv
// rtl/func_arbiter_pkg.sv - shared widths, return word type and split helper
package func_arbiter_pkg;

  localparam int RET_DW     = 16;
  localparam int ROB_W      = 4;
  localparam int CALL_SEQ_W = 8;
  localparam int CHILD_N    = 4;
  localparam int CHILD_ID_W = (CHILD_N == 1) ? 1 : $clog2(CHILD_N);

  // One word of the per-parent return FIFO, child id in the MSBs
  typedef struct packed {
    logic [CHILD_ID_W-1:0] child;
    logic [RET_DW-1:0]     val;
  } ret_word_t;

  function automatic ret_word_t splitRetWord(input logic [CHILD_ID_W+RET_DW-1:0] dout);
    return ret_word_t'(dout);
  endfunction

endpackage

// File: rtl/parent_ret_rob_if.sv
// rtl/parent_ret_rob_if.sv - call, return-FIFO and result bundle of the parent reorder buffer
interface parent_ret_rob_if #(
  parameter int LOG_CHILD = 2,
  parameter int RET_DW    = 16,
  parameter int LOG_ROB   = 2
);
  logic                        call_vld_i;
  logic [LOG_CHILD-1:0]        call_child_i;
  logic                        call_rdy_o;
  logic [LOG_ROB-1:0]          call_tag_o;
  logic                        retFifo_empty_n_i;
  logic [LOG_CHILD+RET_DW-1:0] retFifo_dout_i;
  logic                        retFifo_pop_o;
  logic                        ret_vld_o;
  logic                        ret_rdy_i;
  logic [RET_DW-1:0]           ret_data_o;
  logic [LOG_ROB-1:0]          ret_tag_o;
  logic                        err_o;

  // Reorder buffer side
  modport slave (
    input  call_vld_i, call_child_i, retFifo_empty_n_i, retFifo_dout_i, ret_rdy_i,
    output call_rdy_o, call_tag_o, retFifo_pop_o, ret_vld_o, ret_data_o, ret_tag_o, err_o
  );

  // Parent core / return FIFO side
  modport master (
    output call_vld_i, call_child_i, retFifo_empty_n_i, retFifo_dout_i, ret_rdy_i,
    input  call_rdy_o, call_tag_o, retFifo_pop_o, ret_vld_o, ret_data_o, ret_tag_o, err_o
  );
endinterface

// File: rtl/parent_ret_rob_ret_tag_fifo.sv
// rtl/parent_ret_rob_ret_tag_fifo.sv - per-child FIFO of outstanding reorder slot tags
module ret_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH == 1) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  // Extra pointer MSB separates full from empty when the index bits match
  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popData = mem[rdPtr[AW-1:0]];

  // Pointer update, cleared on reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Tag storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (push && !full) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/parent_ret_rob.sv
// rtl/parent_ret_rob.sv - parent-side reorder buffer releasing child returns in call order
module parent_ret_rob #(
  parameter int CHILD     = func_arbiter_pkg::CHILD_N,
  parameter int LOG_CHILD = (CHILD == 1) ? 1 : $clog2(CHILD),
  parameter int RET_DW    = func_arbiter_pkg::RET_DW,
  parameter int ROB_W     = func_arbiter_pkg::ROB_W
) (
  input logic                clk,
  input logic                rstn,
  parent_ret_rob_if.slave    bus
);
  import func_arbiter_pkg::*;

  localparam int LOG_ROB = $clog2(ROB_W);
  localparam logic [LOG_ROB:0] ROB_FULL = (LOG_ROB + 1)'(ROB_W);

  logic [LOG_ROB-1:0] head;
  logic [LOG_ROB-1:0] tail;
  logic [LOG_ROB:0]   cnt;
  logic [ROB_W-1:0]   slotVld;
  logic [RET_DW-1:0]  robData [ROB_W];

  logic [CHILD-1:0]   tagPush;
  logic [CHILD-1:0]   tagPop;
  logic [CHILD-1:0]   tagEmpty;
  logic [CHILD-1:0]   tagFull;
  logic [LOG_ROB-1:0] tagOut [CHILD];

  ret_word_t          word;
  logic               fireCall;
  logic               fireRet;
  logic               intakeHit;
  logic               intakeMiss;
  logic [LOG_ROB-1:0] intakeSlot;

  assign word = splitRetWord(bus.retFifo_dout_i);

  // Allocation looks only at registered cnt, so a slot freed this cycle is reusable next cycle
  assign bus.call_rdy_o = (cnt < ROB_FULL);
  assign bus.call_tag_o = tail;
  assign fireCall       = bus.call_vld_i & bus.call_rdy_o;

  // Always drain; tag FIFO state is registered so a same-cycle call cannot satisfy this word
  assign bus.retFifo_pop_o = bus.retFifo_empty_n_i;
  assign intakeHit         = bus.retFifo_empty_n_i & ~tagEmpty[word.child];
  assign intakeMiss        = bus.retFifo_empty_n_i &  tagEmpty[word.child];
  assign intakeSlot        = tagOut[word.child];

  assign bus.ret_vld_o  = slotVld[head];
  assign bus.ret_data_o = robData[head];
  assign bus.ret_tag_o  = head;
  assign fireRet        = bus.ret_vld_o & bus.ret_rdy_i;

  // Route push to the called child's tag FIFO and pop to the returning child's
  always_comb begin
    tagPush = '0;
    tagPop  = '0;
    if (fireCall && !tagFull[bus.call_child_i]) tagPush[bus.call_child_i] = 1'b1;
    if (intakeHit) tagPop[word.child] = 1'b1;
  end

  for (genvar g = 0; g < CHILD; g++) begin : g_tag
    ret_tag_fifo #(
      .WIDTH (LOG_ROB),
      .DEPTH (ROB_W)
    ) u_tag_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (tagPush[g]),
      .pushData (tail),
      .pop      (tagPop[g]),
      .popData  (tagOut[g]),
      .empty    (tagEmpty[g]),
      .full     (tagFull[g])
    );
  end

  // Slot bookkeeping: allocate at tail, fill on intake, retire at head
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      slotVld   <= '0;
      bus.err_o <= 1'b0;
      for (int i = 0; i < ROB_W; i++) robData[i] <= '0;
    end else begin
      if (fireCall) begin
        slotVld[tail] <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (fireRet) begin
        slotVld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // Intake slot is outstanding, so it never collides with tail or a valid head
      if (intakeHit) begin
        robData[intakeSlot] <= word.val;
        slotVld[intakeSlot] <= 1'b1;
      end
      if (intakeMiss) bus.err_o <= 1'b1;
      case ({fireCall, fireRet})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_parent_ret_rob.sv
// tb/tb_parent_ret_rob.sv - directed self-checking bench for parent_ret_rob
module tb_parent_ret_rob;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  parent_ret_rob_if #(.LOG_CHILD(2), .RET_DW(16), .LOG_ROB(2)) bus ();

  parent_ret_rob dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic retWord(input int c, input int v);
    bus.retFifo_dout_i = {c[1:0], v[15:0]};
  endtask

  task automatic call(input int c, input int expTag, input string tag);
    bus.call_vld_i   = 1'b1;
    bus.call_child_i = c[1:0];
    #1;
    chk(tag, bus.call_tag_o, expTag);
    step();
  endtask

  task automatic res(input int expData, input int expTag, input string tag);
    chk({tag, "_vld"}, bus.ret_vld_o, 1);
    chk({tag, "_data"}, bus.ret_data_o, expData);
    chk({tag, "_tag"}, bus.ret_tag_o, expTag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn                  = 1'b0;
    bus.call_vld_i        = 1'b0;
    bus.call_child_i      = '0;
    bus.retFifo_empty_n_i = 1'b0;
    bus.retFifo_dout_i    = '0;
    bus.ret_rdy_i         = 1'b0;
    step();
    step();
    rstn = 1'b1;
    #1;
    chk("rst_call_rdy", bus.call_rdy_o, 1);
    chk("rst_ret_vld", bus.ret_vld_o, 0);
    chk("rst_pop", bus.retFifo_pop_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_call_tag", bus.call_tag_o, 0);

    // In-order returns
    bus.ret_rdy_i = 1'b1;
    call(0, 0, "io_tag0");
    call(1, 1, "io_tag1");
    call(2, 2, "io_tag2");
    bus.call_vld_i = 1'b0;
    retWord(0, 'hA);
    bus.retFifo_empty_n_i = 1'b1;
    #1;
    chk("io_pop", bus.retFifo_pop_o, 1);
    chk("io_no_bypass", bus.ret_vld_o, 0);
    step();
    retWord(1, 'hB);
    res('hA, 0, "io_a");
    step();
    retWord(2, 'hC);
    res('hB, 1, "io_b");
    step();
    bus.retFifo_empty_n_i = 1'b0;
    res('hC, 2, "io_c");
    step();
    chk("io_idle", bus.ret_vld_o, 0);

    // Out-of-order across children
    call(0, 3, "ooo_tag3");
    call(1, 0, "ooo_tag0");
    bus.call_vld_i = 1'b0;
    retWord(1, 'h22);
    bus.retFifo_empty_n_i = 1'b1;
    step();
    retWord(0, 'h11);
    #1;
    chk("ooo_wait", bus.ret_vld_o, 0);
    step();
    bus.retFifo_empty_n_i = 1'b0;
    res('h11, 3, "ooo_11");
    step();
    res('h22, 0, "ooo_22");
    step();
    chk("ooo_idle", bus.ret_vld_o, 0);

    // Same child several times
    bus.ret_rdy_i = 1'b0;
    call(3, 1, "sc_tag1");
    call(0, 2, "sc_tag2");
    call(3, 3, "sc_tag3");
    call(3, 0, "sc_tag0");
    bus.call_vld_i = 1'b0;
    bus.retFifo_empty_n_i = 1'b1;
    retWord(3, 1); step();
    retWord(3, 2); step();
    retWord(3, 3); step();
    retWord(0, 9); step();
    bus.retFifo_empty_n_i = 1'b0;
    res(1, 1, "sc_r0");
    bus.ret_rdy_i = 1'b1;
    step();
    res(9, 2, "sc_r1");
    step();
    res(2, 3, "sc_r2");
    step();
    res(3, 0, "sc_r3");
    step();
    chk("sc_idle", bus.ret_vld_o, 0);

    // Full and backpressure
    bus.ret_rdy_i = 1'b0;
    call(0, 1, "full_tag1");
    call(1, 2, "full_tag2");
    call(2, 3, "full_tag3");
    call(3, 0, "full_wrap");
    bus.call_vld_i   = 1'b1;
    bus.call_child_i = 2'd1;
    #1;
    chk("full_rdy0", bus.call_rdy_o, 0);
    chk("full_tag_hold", bus.call_tag_o, 1);
    retWord(0, 'h55);
    bus.retFifo_empty_n_i = 1'b1;
    step();
    bus.retFifo_empty_n_i = 1'b0;
    res('h55, 1, "full_head");
    step();
    res('h55, 1, "full_stall");
    chk("full_rdy0b", bus.call_rdy_o, 0);
    bus.ret_rdy_i = 1'b1;
    step();
    bus.ret_rdy_i = 1'b0;
    #1;
    chk("full_rdy1", bus.call_rdy_o, 1);
    chk("full_reuse_tag", bus.call_tag_o, 1);
    chk("full_next_vld", bus.ret_vld_o, 0);
    step();
    bus.call_vld_i = 1'b0;
    #1;
    chk("full_again", bus.call_rdy_o, 0);
    bus.retFifo_empty_n_i = 1'b1;
    retWord(1, 'h61); step();
    retWord(2, 'h62); step();
    retWord(3, 'h63); step();
    retWord(1, 'h64); step();
    bus.retFifo_empty_n_i = 1'b0;
    bus.ret_rdy_i = 1'b1;
    res('h61, 2, "drain0");
    step();
    res('h62, 3, "drain1");
    step();
    res('h63, 0, "drain2");
    step();
    res('h64, 1, "drain3");
    step();
    chk("drain_idle", bus.ret_vld_o, 0);
    chk("drain_rdy", bus.call_rdy_o, 1);

    // Return with no outstanding call
    retWord(2, 'h77);
    bus.retFifo_empty_n_i = 1'b1;
    #1;
    chk("err_pop", bus.retFifo_pop_o, 1);
    step();
    bus.retFifo_empty_n_i = 1'b0;
    #1;
    chk("err_set", bus.err_o, 1);
    chk("err_no_vld", bus.ret_vld_o, 0);
    call(2, 2, "err_tag2");
    bus.call_vld_i = 1'b0;
    retWord(2, 'h88);
    bus.retFifo_empty_n_i = 1'b1;
    step();
    bus.retFifo_empty_n_i = 1'b0;
    res('h88, 2, "err_after");
    step();
    chk("err_idle", bus.ret_vld_o, 0);
    chk("err_sticky", bus.err_o, 1);

    // Reset mid-flight
    bus.ret_rdy_i = 1'b0;
    call(0, 3, "mr_tag3");
    call(1, 0, "mr_tag0");
    call(2, 1, "mr_tag1");
    call(3, 2, "mr_tag2");
    bus.call_vld_i = 1'b0;
    bus.retFifo_empty_n_i = 1'b1;
    retWord(0, 'h10); step();
    retWord(1, 'h20); step();
    bus.retFifo_empty_n_i = 1'b0;
    res('h10, 3, "mr_pre");
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
    chk("mr_cnt", dut.cnt, 0);
    chk("mr_vld", bus.ret_vld_o, 0);
    chk("mr_rdy", bus.call_rdy_o, 1);
    chk("mr_tag", bus.call_tag_o, 0);
    chk("mr_err", bus.err_o, 0);

    // Same-cycle call and return to that child: the return is not matched
    bus.call_vld_i   = 1'b1;
    bus.call_child_i = 2'd1;
    retWord(1, 'h99);
    bus.retFifo_empty_n_i = 1'b1;
    step();
    bus.call_vld_i = 1'b0;
    bus.retFifo_empty_n_i = 1'b0;
    #1;
    chk("same_cyc_err", bus.err_o, 1);
    chk("same_cyc_vld", bus.ret_vld_o, 0);
    chk("same_cyc_tag", bus.call_tag_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
